uart_rx_os: RTL

- Next-generation UART receiver. Replaces the fixed-parameter receiver that samples each bit once at mid-bit.
- Runtime-programmable fractional baud divisor feeding a 16x oversampling engine, with 3-sample majority voting per bit.
- Runtime frame format: 5-8 data bits, NONE/ODD/EVEN/MARK/SPACE parity, 1 or 2 stop bits.
- Reports framing, parity, break and overrun conditions; delivers bytes over a valid/ready stream to the host-side FIFO.

---
 rtl/uart_rx_os_if.sv | 11 +
 rtl/uart_rx_os.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: received-byte stream with per-word status flags
interface uart_rx_os_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_frame_err;
   logic       m_parity_err;
   logic       m_break;
   modport master (output m_data, m_valid, m_frame_err, m_parity_err, m_break, input m_ready);
   modport slave (input m_data, m_valid, m_frame_err, m_parity_err, m_break, output m_ready);
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with fractional baud and runtime frame format
module uart_rx_os #(
   parameter int DIV_W       = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             uart_rx,
   input  logic [DIV_W-1:0] baud_div,
   input  logic [3:0]       baud_frac,
   input  logic [1:0]       cfg_data_bits,
   input  logic [2:0]       cfg_parity,
   input  logic             cfg_stop2,
   uart_rx_os_if.master     m,
   output logic             overrun,
   output logic             rx_busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] sync;
   logic rx_s, rx_d, fall, start;
   logic [DIV_W-1:0] div_l;
   logic [3:0] frac_l, acc, os_cnt;
   logic carry, tick, bit_end, mid9;
   logic [DIV_W:0] div_cnt;
   logic [2:0] nbits_l, bit_cnt, par_l;
   logic stop2_l, stop_idx;
   logic s7, s8, bit_val, maj, par_exp;
   logic [7:0] sh, sh_sr, sh_nxt;
   logic perr, ferr, zero, brk_c, ferr_c;

   assign rx_s    = sync[SYNC_STAGES-1];
   assign fall    = rx_d & ~rx_s;
   assign start   = (state == IDLE) && fall;
   // a tick closes a period of div_l clocks, stretched by one after an accumulator carry
   assign tick    = (state != IDLE) && (div_cnt == ({1'b0, div_l} - {{DIV_W{1'b0}}, ~carry}));
   assign bit_end = tick && (os_cnt == 4'd15);
   assign mid9    = tick && (os_cnt == 4'd9);
   assign maj     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
   assign sh_sr   = {1'b0, sh[7:1]};
   assign par_exp = (par_l == 3'd1) ? ~^sh : (par_l == 3'd2) ? ^sh : (par_l == 3'd3);
   assign brk_c   = zero & (stop2_l | ~maj);
   assign ferr_c  = ferr | ~maj;

   // new data bit lands at position N-1 while earlier bits move toward the LSB
   always_comb begin
      sh_nxt = '0;
      for (int i = 0; i < 8; i++)
         sh_nxt[i] = (i == int'(nbits_l)) ? bit_val : (i < int'(nbits_l)) ? sh_sr[i] : 1'b0;
   end

   // metastability synchroniser plus one delayed copy for edge detection, idling high
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '1;
         rx_d <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], uart_rx};
         rx_d <= rx_s;
      end
   end

   // fractional divider producing the 16x tick, restarted on each start edge
   always_ff @(posedge clk) begin
      if (rst || start) begin
         div_cnt <= '0;
         acc     <= '0;
         carry   <= 1'b0;
      end else if (state != IDLE) begin
         if (tick) begin
            div_cnt      <= '0;
            {carry, acc} <= 5'(acc) + 5'(frac_l);
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // frame FSM with majority sampling, error tracking and the output holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rx_busy        <= 1'b0;
         overrun        <= 1'b0;
         m.m_valid      <= 1'b0;
         m.m_data       <= '0;
         m.m_frame_err  <= 1'b0;
         m.m_parity_err <= 1'b0;
         m.m_break      <= 1'b0;
         os_cnt         <= '0;
         s7             <= 1'b1;
         s8             <= 1'b1;
         bit_val        <= 1'b1;
         div_l          <= DIV_W'(4);
         frac_l         <= '0;
         nbits_l        <= 3'd7;
         par_l          <= '0;
         stop2_l        <= 1'b0;
         bit_cnt        <= '0;
         stop_idx       <= 1'b0;
         sh             <= '0;
         perr           <= 1'b0;
         ferr           <= 1'b0;
         zero           <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (m.m_valid && m.m_ready) m.m_valid <= 1'b0;
         if (tick) os_cnt <= os_cnt + 4'd1;
         if (tick && os_cnt == 4'd7) s7 <= rx_s;
         if (tick && os_cnt == 4'd8) s8 <= rx_s;
         if (mid9) bit_val <= maj;
         case (state)
            IDLE: if (fall) begin
               state    <= START;
               rx_busy  <= 1'b1;
               os_cnt   <= '0;
               div_l    <= (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
               frac_l   <= baud_frac;
               nbits_l  <= 3'(cfg_data_bits) + 3'd4;
               par_l    <= (cfg_parity > 3'd4) ? 3'd0 : cfg_parity;
               stop2_l  <= cfg_stop2;
               bit_cnt  <= '0;
               stop_idx <= 1'b0;
               sh       <= '0;
               perr     <= 1'b0;
               ferr     <= 1'b0;
               zero     <= 1'b1;
            end
            START: if (bit_end) begin
               state   <= bit_val ? IDLE : DATA;
               rx_busy <= ~bit_val;
            end
            DATA: if (bit_end) begin
               sh      <= sh_nxt;
               zero    <= zero & ~bit_val;
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == nbits_l) state <= (par_l != 3'd0) ? PARITY : STOP;
            end
            PARITY: if (bit_end) begin
               perr  <= bit_val != par_exp;
               zero  <= zero & ~bit_val;
               state <= STOP;
            end
            STOP: begin
               if (mid9 && stop_idx == stop2_l) begin
                  if (!m.m_valid || m.m_ready) begin
                     m.m_valid      <= 1'b1;
                     m.m_data       <= brk_c ? 8'h00 : sh;
                     m.m_frame_err  <= ferr_c;
                     m.m_parity_err <= perr;
                     m.m_break      <= brk_c;
                  end else begin
                     overrun <= 1'b1;
                  end
                  state   <= brk_c ? BREAK_WAIT : IDLE;
                  rx_busy <= brk_c;
               end else if (mid9) begin
                  ferr <= ferr_c;
                  zero <= zero & ~maj;
               end else if (bit_end) begin
                  stop_idx <= 1'b1;
               end
            end
            BREAK_WAIT: if (rx_s) begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
